// File: rtl/led_bcd_converter_if.sv
// Handshake bundle between the binary source, the BCD converter and the display driver.
// The producer (master) drives the request; the converter (slave) returns digits and status.
interface led_bcd_converter_if;
    logic [31:0] bin_in;
    logic [1:0]  mode;
    logic        start;
    logic [31:0] digits;
    logic        valid;
    logic        busy;
    logic        overflow;

    modport master (
        output bin_in, mode, start,
        input  digits, valid, busy, overflow
    );

    modport slave (
        input  bin_in, mode, start,
        output digits, valid, busy, overflow
    );
endinterface

// File: rtl/led_bcd_converter.sv
// Binary-to-BCD stage for the seven-segment display: 32-step double-dabble engine,
// or a one-cycle hex pass-through when mode is 2'b00.
module led_bcd_converter (
    input  logic                 clk_N,
    input  logic                 rst,
    led_bcd_converter_if.slave   bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]  r_state;
    logic [5:0]  r_cnt;
    logic [71:0] r_work;
    logic [31:0] r_digits;
    logic        r_valid;
    logic        r_busy;
    logic        r_ovf;

    logic [71:0] w_adj;
    logic [71:0] w_shift;

    // Upper 40 bits of the work register hold 10 BCD nibbles; the corrected
    // nibble never exceeds 12, so the 4-bit add cannot carry out.
    function automatic logic [71:0] add3_nibbles(input logic [71:0] w);
        logic [71:0] r;
        r = w;
        for (int k = 0; k < 10; k++) begin
            if (r[32 + 4*k +: 4] >= 4'd5)
                r[32 + 4*k +: 4] = r[32 + 4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign w_adj   = add3_nibbles(r_work);
    assign w_shift = {w_adj[70:0], 1'b0};

    always_ff @(posedge clk_N) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_work   <= 72'd0;
            r_digits <= 32'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.mode == 2'b00) begin
                            r_digits <= bus.bin_in;
                            r_ovf    <= 1'b0;
                            r_valid  <= 1'b1;
                        end else begin
                            r_work  <= {40'd0, bus.bin_in};
                            r_cnt   <= 6'd0;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // start is deliberately ignored here; no queuing, no restart
                    r_work <= w_shift;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_digits <= w_shift[63:32];
                        r_ovf    <= |w_shift[71:64];
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.digits   = r_digits;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_led_bcd_converter.sv
// Bench for led_bcd_converter: vector table plus hand sequences for busy-start and mid-conversion reset.
module tb_led_bcd_converter;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] bin;
        logic [31:0] d;
        logic        o;
        string       name;
    } vec_t;

    logic clk_N = 1'b0;
    logic rst   = 1'b1;

    led_bcd_converter_if bus ();

    led_bcd_converter dut (
        .clk_N (clk_N),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_N = ~clk_N;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, and score any valid output.
    task automatic step();
        exp_t e;
        @(posedge clk_N);
        #1;
        if (bus.valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got digits %h with no result pending", bus.digits);
            end else begin
                e = sb.pop_front();
                check("sb_digits", bus.digits, e.d);
                check("sb_overflow", {31'd0, bus.overflow}, {31'd0, e.o});
            end
        end
    endtask

    task automatic run_one(input logic [1:0] m, input logic [31:0] b,
                           input logic [31:0] ed, input logic eo, input string name);
        int   v0;
        logic bad;
        v0 = nvalid;
        bus.mode   = m;
        bus.bin_in = b;
        bus.start  = 1'b1;
        sb.push_back('{ed, eo});
        step();
        bus.start = 1'b0;
        if (m == 2'b00) begin
            check({name, "_hex_valid"}, {31'd0, bus.valid}, 32'd1);
            check({name, "_hex_busy"},  {31'd0, bus.busy},  32'd0);
        end else begin
            check({name, "_busy_N"},  {31'd0, bus.busy},  32'd1);
            check({name, "_valid_N"}, {31'd0, bus.valid}, 32'd0);
            bad = 1'b0;
            for (int k = 1; k < 32; k++) begin
                step();
                if (bus.busy !== 1'b1 || bus.valid !== 1'b0) bad = 1'b1;
            end
            check({name, "_busy_window"}, {31'd0, bad}, 32'd0);
            step();
            check({name, "_valid_N32"}, {31'd0, bus.valid}, 32'd1);
            check({name, "_busy_N32"},  {31'd0, bus.busy},  32'd0);
        end
        step();
        check({name, "_no_repeat"}, {31'd0, bus.valid}, 32'd0);
        check({name, "_one_valid"}, nvalid - v0, 32'd1);
    endtask

    initial begin
        logic bad;
        int   v0;

        vecs[0] = '{2'b01, 32'd12345678,   32'h12345678, 1'b0, "dec_basic"};
        vecs[1] = '{2'b10, 32'd0,          32'h00000000, 1'b0, "dec_zero"};
        vecs[2] = '{2'b11, 32'd99999999,   32'h99999999, 1'b0, "dec_max8"};
        vecs[3] = '{2'b01, 32'd4294967295, 32'h94967295, 1'b1, "dec_max32"};
        vecs[4] = '{2'b00, 32'hDEADBEEF,   32'hDEADBEEF, 1'b0, "hex_dead"};
        vecs[5] = '{2'b01, 32'd100000000,  32'h00000000, 1'b1, "dec_1e8"};
        vecs[6] = '{2'b01, 32'd9,          32'h00000009, 1'b0, "dec_nine"};
        vecs[7] = '{2'b00, 32'h0000ABCD,   32'h0000ABCD, 1'b0, "hex_abcd"};

        bus.bin_in = 32'd0;
        bus.mode   = 2'b00;
        bus.start  = 1'b0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_digits",   bus.digits, 32'd0);
        check("reset_valid",    {31'd0, bus.valid},    32'd0);
        check("reset_busy",     {31'd0, bus.busy},     32'd0);
        check("reset_overflow", {31'd0, bus.overflow}, 32'd0);

        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.digits !== 32'd0)
                bad = 1'b1;
        end
        check("idle_quiet", {31'd0, bad}, 32'd0);

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].mode, vecs[i].bin, vecs[i].d, vecs[i].o, vecs[i].name);

        // digits/overflow hold after completion
        for (int i = 0; i < 5; i++) step();
        check("hold_digits", bus.digits, 32'h0000ABCD);

        // start while busy is ignored
        v0 = nvalid;
        bus.mode   = 2'b01;
        bus.bin_in = 32'd1000;
        bus.start  = 1'b1;
        sb.push_back('{32'h00001000, 1'b0});
        step();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        bus.bin_in = 32'd7;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 11; k < 32; k++) step();
        check("busy_start_pre", nvalid - v0, 32'd0);
        step();
        check("busy_start_valid_N32", {31'd0, bus.valid}, 32'd1);
        for (int k = 0; k < 40; k++) step();
        check("busy_start_single", nvalid - v0, 32'd1);
        check("busy_start_busy_idle", {31'd0, bus.busy}, 32'd0);

        // reset mid-conversion aborts with no valid
        v0 = nvalid;
        bus.bin_in = 32'd55555;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k < 12; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy",     {31'd0, bus.busy},     32'd0);
        check("midrst_digits",   bus.digits,            32'd0);
        check("midrst_valid",    {31'd0, bus.valid},    32'd0);
        check("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
        for (int k = 0; k < 40; k++) step();
        check("midrst_no_valid", nvalid - v0, 32'd0);
        run_one(2'b01, 32'd42, 32'h00000042, 1'b0, "after_rst_42");

        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
